egress_pkt_fifo: RTL and testbench
==================================

EGRESS_PKT_FIFO -- requirements
Module: egress_pkt_fifo

Interface
REQ-001 Parameter DEPTH, default 64, word capacity; power of two, 4..1024.
REQ-002 Parameter ADDR_W, default $clog2(DEPTH), RAM address width.
REQ-003 clk  in  1  clock; all logic on posedge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 en  in  1  block enable; low blocks ingress acceptance.
REQ-006 ingress_source  in  axis_d_source_t  tvalid, tdata[15:0], tdest[1:0], tlast from the filter stage.
REQ-007 ingress_sink  out  axis_d_sink_t  tready to the filter stage.
REQ-008 egress_source  out  axis_d_source_t  buffered packet stream.
REQ-009 egress_sink  in  axis_d_sink_t  tready from the downstream port.
REQ-010 drop_count  out  16  dropped-packet count; present only with EGRESS_PKT_FIFO_DROP_CNT_EN.

Function
REQ-011 Store-and-forward: no word of a packet appears on egress until its tlast word is written.
REQ-012 Ingress tready SHALL equal en, registered-free (combinational); overflow never back-pressures, it drops.
REQ-013 Beat accepted when ingress tvalid and tready; each entry stores {tdest, tlast, tdata} (19 bits).
REQ-014 Pointers wr_ptr, commit_ptr, rd_ptr are ADDR_W+1 bits, wrap modulo 2*DEPTH; full when wr_ptr-rd_ptr == DEPTH.
REQ-015 Write FSM states IDLE, STORE, DROP; reset state IDLE.
REQ-016 IDLE/STORE, accepted beat, not full: write at wr_ptr, wr_ptr+1; tlast -> commit_ptr <= wr_ptr+1, go IDLE; else go STORE.
REQ-017 IDLE/STORE, accepted beat while full: wr_ptr <= commit_ptr (rewind), drop event; tlast -> IDLE, else -> DROP.
REQ-018 DROP: accepted beats discarded; tlast beat -> IDLE. No writes in DROP.
REQ-019 Full evaluated on pre-cycle pointers; a same-cycle egress read does not free space for that cycle's write.
REQ-020 Packets longer than DEPTH words are always dropped whole; no partial packet ever reaches egress.
REQ-021 Readable when rd_ptr != commit_ptr; RAM read is one-cycle registered; egress driven from an output register.
REQ-022 Egress tvalid, once high, holds with tdata/tdest/tlast stable until egress tready; no bubbles between words of a committed packet when tready held high.
REQ-023 Latency: tlast accepted at cycle N -> first word of that packet on egress tvalid no earlier than N+2, no later than N+3 when FIFO otherwise empty.
REQ-024 en low: ingress blocked; FSM state held (mid-packet STORE resumes when en returns); egress continues draining committed data.
REQ-025 Simultaneous commit and final read of prior packet: new packet readable next cycle, no loss.

Reset
REQ-026 On reset: all pointers 0, FSM IDLE, egress tvalid/tlast 0, tdata 16'h0000, tdest 2'b00, drop_count 0.
REQ-027 Reset mid-operation discards all stored (committed and uncommitted) data; first post-reset beat starts a new packet.
REQ-028 Ingress tready during reset SHALL be 0.

Configuration
REQ-029 Macro EGRESS_PKT_FIFO_DROP_CNT_EN: defined -> drop_count port present, +1 per drop event (REQ-017), saturating at 16'hFFFF.
REQ-030 Undefined -> no drop_count port, no counter logic; datapath behaviour identical.

Structure
REQ-031 axis_d_source_t/axis_d_sink_t from the shared packet_filter package; write-FSM state enum and entry width constant (19) added there.
REQ-032 Storage in sub-module pkt_fifo_ram: simple dual-port, one write port, one registered read port, DEPTH x 19.

Verification
REQ-033 3-word packet 16'h0001..0003, tdest 2, egress tready=1 -> identical 3 words, tdest 2, tlast on 3rd, first tvalid within 3 cycles of tlast.
REQ-034 DEPTH=8, write 6-word then 4-word packet with egress tready=0 -> first kept, second dropped, drop_count 1; release tready -> only 6 words out.
REQ-035 12-word packet into empty DEPTH=8 FIFO -> nothing on egress, FSM returns IDLE after tlast, drop_count 1.
REQ-036 Random egress tready stalls over 100 packets, no overflow -> output equals input word-for-word, tvalid/data stable during stalls.
REQ-037 Reset asserted after 2 words of a packet and with 1 committed packet stored -> egress tvalid 0 next cycle, no residual words after reset.
REQ-038 en dropped mid-packet for 5 cycles then restored -> ingress tready 0 during, packet completes intact afterwards.

Source files
------------

// File: rtl/packet_filter_pkg.sv
// Shared packet_filter types: AXI-stream style source/sink bundles, egress FIFO
// entry width and write-side FSM states.
package packet_filter_pkg;

    typedef struct packed {
        logic        tvalid;
        logic [15:0] tdata;
        logic [1:0]  tdest;
        logic        tlast;
    } axis_d_source_t;

    typedef struct packed {
        logic tready;
    } axis_d_sink_t;

    localparam int unsigned EntryW = 19;

    typedef enum logic [1:0] {
        StIdle,
        StStore,
        StDrop
    } wr_state_e;

    function automatic logic [EntryW-1:0] pack_entry(input axis_d_source_t s);
        return {s.tdest, s.tlast, s.tdata};
    endfunction

    function automatic axis_d_source_t unpack_entry(input logic [EntryW-1:0] e);
        axis_d_source_t s;
        s.tvalid = 1'b1;
        s.tdest  = e[18:17];
        s.tlast  = e[16];
        s.tdata  = e[15:0];
        return s;
    endfunction

endpackage

// File: rtl/pkt_fifo_ram.sv
// Simple dual-port storage for egress_pkt_fifo: one write port, one registered read port.
module pkt_fifo_ram #(
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned ADDR_W = $clog2(DEPTH),
    parameter int unsigned WIDTH  = 19
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/egress_pkt_fifo.sv
// Store-and-forward egress packet FIFO; packets that overflow are dropped whole.
// Define EGRESS_PKT_FIFO_DROP_CNT_EN to add the saturating drop_count output.
module egress_pkt_fifo
    import packet_filter_pkg::*;
#(
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           en,
    input  axis_d_source_t ingress_source,
    output axis_d_sink_t   ingress_sink,
    output axis_d_source_t egress_source,
    input  axis_d_sink_t   egress_sink
`ifdef EGRESS_PKT_FIFO_DROP_CNT_EN
    ,
    output logic [15:0]    drop_count
`endif
);

    localparam logic [ADDR_W:0] FullLevel = (ADDR_W + 1)'(DEPTH);

    wr_state_e         wr_state;
    logic [ADDR_W:0]   wr_ptr, commit_ptr, rd_ptr, fetch_ptr;
    logic              accept, full, do_write;
    logic              fetch_en, ram_valid, r_move, pop;
    logic [EntryW-1:0] ram_rdata;

    assign ingress_sink.tready = en & ~reset;
    assign accept   = ingress_source.tvalid & ingress_sink.tready;
    // rd_ptr only moves on an egress handshake, so prefetched words still occupy space
    assign full     = (wr_ptr - rd_ptr) == FullLevel;
    assign do_write = accept & (wr_state != StDrop) & ~full;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_state   <= StIdle;
            wr_ptr     <= '0;
            commit_ptr <= '0;
        end else if (accept) begin
            unique case (wr_state)
                StIdle, StStore: begin
                    if (!full) begin
                        wr_ptr <= wr_ptr + 1'b1;
                        if (ingress_source.tlast) begin
                            commit_ptr <= wr_ptr + 1'b1;
                            wr_state   <= StIdle;
                        end else begin
                            wr_state <= StStore;
                        end
                    end else begin
                        wr_ptr   <= commit_ptr;
                        wr_state <= ingress_source.tlast ? StIdle : StDrop;
                    end
                end
                StDrop: begin
                    if (ingress_source.tlast) begin
                        wr_state <= StIdle;
                    end
                end
                default: wr_state <= StIdle;
            endcase
        end
    end

`ifdef EGRESS_PKT_FIFO_DROP_CNT_EN
    logic drop_evt;
    assign drop_evt = accept & (wr_state != StDrop) & full;

    always_ff @(posedge clk) begin
        if (reset) begin
            drop_count <= '0;
        end else if (drop_evt && drop_count != 16'hFFFF) begin
            drop_count <= drop_count + 16'd1;
        end
    end
`endif

    pkt_fifo_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .WIDTH  (EntryW)
    ) u_ram (
        .clk   (clk),
        .we    (do_write),
        .waddr (wr_ptr[ADDR_W-1:0]),
        .wdata (pack_entry(ingress_source)),
        .re    (fetch_en),
        .raddr (fetch_ptr[ADDR_W-1:0]),
        .rdata (ram_rdata)
    );

    // Two-stage read pipe (RAM data, output register); RAM data holds while stalled.
    assign pop      = egress_source.tvalid & egress_sink.tready;
    assign r_move   = ram_valid & (~egress_source.tvalid | egress_sink.tready);
    assign fetch_en = (fetch_ptr != commit_ptr) & (~ram_valid | r_move);

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_ptr     <= '0;
            rd_ptr        <= '0;
            ram_valid     <= 1'b0;
            egress_source <= '0;
        end else begin
            if (fetch_en) begin
                fetch_ptr <= fetch_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (fetch_en) begin
                ram_valid <= 1'b1;
            end else if (r_move) begin
                ram_valid <= 1'b0;
            end
            if (r_move) begin
                egress_source <= unpack_entry(ram_rdata);
            end else if (pop) begin
                egress_source.tvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_egress_pkt_fifo.sv
// Self-checking bench for egress_pkt_fifo (DEPTH=8) against a queue-based packet model.
module tb_egress_pkt_fifo;
    import packet_filter_pkg::*;

    localparam int unsigned DEPTH = 8;

    typedef struct packed {
        logic [15:0] tdata;
        logic [1:0]  tdest;
        logic        tlast;
    } word_t;

    logic           clk = 1'b0;
    logic           reset;
    logic           en;
    axis_d_source_t in_src, eg_src;
    axis_d_sink_t   in_snk, eg_snk;
`ifdef EGRESS_PKT_FIFO_DROP_CNT_EN
    logic [15:0]    drop_count;
`endif

    egress_pkt_fifo #(
        .DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .en             (en),
        .ingress_source (in_src),
        .ingress_sink   (in_snk),
        .egress_source  (eg_src),
        .egress_sink    (eg_snk)
`ifdef EGRESS_PKT_FIFO_DROP_CNT_EN
        ,
        .drop_count     (drop_count)
`endif
    );

    always #5 clk = ~clk;

    int    n_cmp = 0;
    int    n_err = 0;
    int    cyc = 0;
    word_t exp_q[$];
    word_t part_q[$];
    word_t got_q[$];
    bit    dropping = 1'b0;
    int    model_drops = 0;
    int    tlast_cyc = -1;
    int    first_valid_cyc = -1;
    bit    prev_stall = 1'b0;
    axis_d_source_t prev_eg;
    bit    stop_rand;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic fail_timeout(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: got timeout expected completion", name);
    endtask

    // Model: occupancy = committed-not-popped + partially written words, judged pre-edge.
    always @(negedge clk) begin
        int    occ;
        word_t w;
        cyc++;
        occ = exp_q.size() + part_q.size();
        check("ingress_tready", in_snk.tready, en && !reset);
        if (prev_stall) begin
            check("stall_valid", eg_src.tvalid, 1);
            check("stall_data", eg_src, prev_eg);
        end
        if (eg_src.tvalid && !reset) check("store_and_forward", exp_q.size() != 0, 1);
`ifdef EGRESS_PKT_FIFO_DROP_CNT_EN
        check("drop_count", drop_count, model_drops);
`endif
        prev_stall = !reset && eg_src.tvalid && !eg_snk.tready;
        prev_eg    = eg_src;
        if (reset) begin
            exp_q.delete();
            part_q.delete();
            dropping    = 1'b0;
            model_drops = 0;
        end else begin
            if (eg_src.tvalid && eg_snk.tready && exp_q.size() != 0) begin
                w = exp_q.pop_front();
                check("egress_word", {eg_src.tdata, eg_src.tdest, eg_src.tlast}, w);
                got_q.push_back(word_t'{eg_src.tdata, eg_src.tdest, eg_src.tlast});
            end
            if (eg_src.tvalid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (in_src.tvalid && in_snk.tready) begin
                w = word_t'{in_src.tdata, in_src.tdest, in_src.tlast};
                if (dropping) begin
                    if (w.tlast) dropping = 1'b0;
                end else if (occ >= DEPTH) begin
                    part_q.delete();
                    if (model_drops < 65535) model_drops++;
                    dropping = !w.tlast;
                end else begin
                    part_q.push_back(w);
                    if (w.tlast) begin
                        foreach (part_q[i]) exp_q.push_back(part_q[i]);
                        part_q.delete();
                        tlast_cyc = cyc;
                    end
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_beat(input logic [15:0] d, input logic [1:0] dest, input logic last);
        int waitc;
        waitc         = 0;
        in_src.tvalid = 1'b1;
        in_src.tdata  = d;
        in_src.tdest  = dest;
        in_src.tlast  = last;
        do begin
            @(negedge clk);
            waitc++;
        end while (!in_snk.tready && waitc < 200);
        if (waitc >= 200) fail_timeout("ingress_accept");
        @(posedge clk);
        #1;
        in_src.tvalid = 1'b0;
    endtask

    task automatic send_pkt(input int len, input logic [15:0] base, input logic [1:0] dest);
        for (int i = 0; i < len; i++) drive_beat(base + 16'(i), dest, i == len - 1);
    endtask

    task automatic wait_drain(input int max);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || eg_src.tvalid) && k < max) begin
            idle(1);
            k++;
        end
        if (k >= max) fail_timeout("egress_drain");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got time limit expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int len;
        int k;
        int sent;
        int base_drops;
        logic [1:0] dest;

        reset         = 1'b1;
        en            = 1'b1;
        in_src        = '0;
        eg_snk.tready = 1'b0;
        idle(3);
        reset = 1'b0;
        check("rst_tvalid", eg_src.tvalid, 0);
        check("rst_tlast", eg_src.tlast, 0);
        check("rst_tdata", eg_src.tdata, 16'h0000);
        check("rst_tdest", eg_src.tdest, 2'b00);

        // 3-word packet, latency and literal content
        eg_snk.tready = 1'b1;
        got_q.delete();
        first_valid_cyc = -1;
        send_pkt(3, 16'h0001, 2'd2);
        wait_drain(100);
        check("latency_window", (first_valid_cyc - tlast_cyc >= 2) && (first_valid_cyc - tlast_cyc <= 3), 1);
        check("p3_count", got_q.size(), 3);
        if (got_q.size() == 3) begin
            check("p3_w0", got_q[0], word_t'{16'h0001, 2'd2, 1'b0});
            check("p3_w1", got_q[1], word_t'{16'h0002, 2'd2, 1'b0});
            check("p3_w2", got_q[2], word_t'{16'h0003, 2'd2, 1'b1});
        end

        // 6 + 4 words into DEPTH=8 with egress stalled: second packet dropped
        eg_snk.tready = 1'b0;
        got_q.delete();
        base_drops = model_drops;
        send_pkt(6, 16'h0100, 2'd1);
        send_pkt(4, 16'h0200, 2'd3);
        idle(4);
        check("ovf_model_drops", model_drops - base_drops, 1);
        check("ovf_model_kept", exp_q.size(), 6);
`ifdef EGRESS_PKT_FIFO_DROP_CNT_EN
        check("ovf_drop_count", drop_count, 16'd1);
`endif
        eg_snk.tready = 1'b1;
        wait_drain(100);
        check("ovf_out_count", got_q.size(), 6);
        if (got_q.size() == 6) check("ovf_last", got_q[5], word_t'{16'h0105, 2'd1, 1'b1});

        // 12-word packet can never fit
        got_q.delete();
        first_valid_cyc = -1;
        base_drops = model_drops;
        send_pkt(12, 16'h0A00, 2'd0);
        idle(10);
        check("long_out_count", got_q.size(), 0);
        check("long_no_valid", first_valid_cyc, -1);
        check("long_model_drops", model_drops - base_drops, 1);
`ifdef EGRESS_PKT_FIFO_DROP_CNT_EN
        check("long_drop_count", drop_count, 16'd2);
`endif
        send_pkt(2, 16'h0B00, 2'd1);
        wait_drain(100);
        check("post_long_count", got_q.size(), 2);
        if (got_q.size() == 2) check("post_long_w0", got_q[0], word_t'{16'h0B00, 2'd1, 1'b0});

        // en low for 5 cycles mid-packet; exactly-DEPTH packet
        got_q.delete();
        fork
            send_pkt(8, 16'h0300, 2'd0);
            begin
                idle(3);
                en = 1'b0;
                idle(5);
                en = 1'b1;
            end
        join
        wait_drain(100);
        check("en_count", got_q.size(), 8);
        if (got_q.size() == 8) check("en_last", got_q[7], word_t'{16'h0307, 2'd0, 1'b1});

        // reset with one committed packet and a partial one
        eg_snk.tready = 1'b0;
        got_q.delete();
        send_pkt(2, 16'h0400, 2'd2);
        drive_beat(16'h0500, 2'd3, 1'b0);
        drive_beat(16'h0501, 2'd3, 1'b0);
        idle(3);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        check("rst_mid_tvalid", eg_src.tvalid, 0);
        eg_snk.tready = 1'b1;
        idle(10);
        check("rst_mid_residual", got_q.size(), 0);
        send_pkt(3, 16'h0600, 2'd1);
        wait_drain(100);
        check("rst_mid_new_count", got_q.size(), 3);
        if (got_q.size() == 3) check("rst_mid_new_w0", got_q[0], word_t'{16'h0600, 2'd1, 1'b0});

        // random traffic with random egress stalls, no overflow
        got_q.delete();
        stop_rand = 1'b0;
        fork
            begin
                while (!stop_rand) begin
                    @(posedge clk);
                    #1;
                    eg_snk.tready = ($urandom_range(0, 9) < 6);
                end
            end
        join_none
        sent = 0;
        for (int p = 0; p < 100; p++) begin
            len  = $urandom_range(1, 6);
            dest = 2'($urandom_range(0, 3));
            for (int i = 0; i < len; i++) begin
                k = 0;
                while (exp_q.size() + part_q.size() >= DEPTH && k < 1000) begin
                    idle(1);
                    k++;
                end
                if (k >= 1000) fail_timeout("rand_space");
                drive_beat(16'($urandom), dest, i == len - 1);
                sent++;
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            end
        end
        stop_rand = 1'b1;
        idle(3);
        eg_snk.tready = 1'b1;
        wait_drain(500);
        check("rand_count", got_q.size(), sent);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
